// File: rtl/serial_arith.sv
// Bit-serial 8-bit add/subtract unit feeding the OV register.
// Sum and difference ripple LSB first in parallel, one bit per clock.
module serial_arith (
    input  logic       CLK,
    input  logic       CPU_Reset,
    input  logic       ALU_EN,
    input  logic [3:0] ALU_OPCode,
    input  logic [7:0] ALU_A,
    input  logic [7:0] ALU_B,
    input  logic       OVREG_OV,
    output logic [8:0] OVREG_Adder,
    output logic [8:0] OVREG_Subtractor,
    output logic [7:0] ALU_Result,
    output logic [3:0] OVREG_OV_OPCode,
    output logic       OV_EN,
    output logic       ALU_Busy,
    output logic       ALU_Done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] cnt_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [7:0] sum_q;
    logic [7:0] dif_q;
    logic       c_q;
    logic       w_q;
    logic       op0_q;

    logic       op_ok;
    logic       start;
    logic       last;
    logic       a_bit;
    logic       b_bit;
    logic       ab_x;
    logic       s_bit;
    logic       d_bit;
    logic       c_nxt;
    logic       w_nxt;
    logic [7:0] sum_fin;
    logic [7:0] dif_fin;

    // Valid opcodes are exactly 4'b10xx; bit 1 selects carry-in, bit 0 add vs sub.
    assign op_ok = (ALU_OPCode[3:2] == 2'b10);
    assign start = ALU_EN & op_ok;
    assign last  = (cnt_q == 3'd7);

    // One full-adder and one full-subtractor slice on the current LSBs.
    assign a_bit = a_q[0];
    assign b_bit = b_q[0];
    assign ab_x  = a_bit ^ b_bit;
    assign s_bit = ab_x ^ c_q;
    assign c_nxt = (a_bit & b_bit) | (ab_x & c_q);
    assign d_bit = ab_x ^ w_q;
    assign w_nxt = (~a_bit & b_bit) | (~ab_x & w_q);

    // Final byte images including the bit produced on the last shift.
    assign sum_fin = {s_bit, sum_q[7:1]};
    assign dif_fin = {d_bit, dif_q[7:1]};

    // State register.
    always_ff @(posedge CLK) begin
        if (CPU_Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        ALU_Busy = 1'b0;
        ALU_Done = 1'b0;
        OV_EN    = 1'b0;
        case (state_q)
            SHIFT: begin
                ALU_Busy = 1'b1;
            end
            DONE: begin
                ALU_Busy = 1'b1;
                ALU_Done = 1'b1;
                OV_EN    = 1'b1;
            end
            default: begin
                ALU_Busy = 1'b0;
            end
        endcase
    end

    // Operand capture, serial datapath and result registers.
    // Results load on the final shift edge so they are visible in DONE.
    always_ff @(posedge CLK) begin
        if (CPU_Reset) begin
            cnt_q            <= 3'd0;
            a_q              <= 8'd0;
            b_q              <= 8'd0;
            sum_q            <= 8'd0;
            dif_q            <= 8'd0;
            c_q              <= 1'b0;
            w_q              <= 1'b0;
            op0_q            <= 1'b0;
            OVREG_Adder      <= 9'd0;
            OVREG_Subtractor <= 9'd0;
            ALU_Result       <= 8'd0;
            OVREG_OV_OPCode  <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q   <= ALU_A;
                        b_q   <= ALU_B;
                        op0_q <= ALU_OPCode[0];
                        c_q   <= ALU_OPCode[1] & OVREG_OV;
                        w_q   <= ALU_OPCode[1] & OVREG_OV;
                        cnt_q <= 3'd0;
                    end
                end
                SHIFT: begin
                    a_q   <= {1'b0, a_q[7:1]};
                    b_q   <= {1'b0, b_q[7:1]};
                    sum_q <= sum_fin;
                    dif_q <= dif_fin;
                    c_q   <= c_nxt;
                    w_q   <= w_nxt;
                    cnt_q <= cnt_q + 3'd1;
                    if (last) begin
                        OVREG_Adder      <= {c_nxt, sum_fin};
                        OVREG_Subtractor <= {w_nxt, dif_fin};
                        ALU_Result       <= op0_q ? sum_fin : dif_fin;
                        OVREG_OV_OPCode  <= {3'b100, op0_q};
                    end
                end
                default: begin
                    cnt_q <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_arith.sv
// Self-checking bench for serial_arith.
// Table vectors, hand-written corner sequences and random ops vs a model.
module tb_serial_arith;

    logic       CLK;
    logic       CPU_Reset;
    logic       ALU_EN;
    logic [3:0] ALU_OPCode;
    logic [7:0] ALU_A;
    logic [7:0] ALU_B;
    logic       OVREG_OV;
    logic [8:0] OVREG_Adder;
    logic [8:0] OVREG_Subtractor;
    logic [7:0] ALU_Result;
    logic [3:0] OVREG_OV_OPCode;
    logic       OV_EN;
    logic       ALU_Busy;
    logic       ALU_Done;

    int tests = 0;
    int fails = 0;

    serial_arith dut (
        .CLK              (CLK),
        .CPU_Reset        (CPU_Reset),
        .ALU_EN           (ALU_EN),
        .ALU_OPCode       (ALU_OPCode),
        .ALU_A            (ALU_A),
        .ALU_B            (ALU_B),
        .OVREG_OV         (OVREG_OV),
        .OVREG_Adder      (OVREG_Adder),
        .OVREG_Subtractor (OVREG_Subtractor),
        .ALU_Result       (ALU_Result),
        .OVREG_OV_OPCode  (OVREG_OV_OPCode),
        .OV_EN            (OV_EN),
        .ALU_Busy         (ALU_Busy),
        .ALU_Done         (ALU_Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       ov;
        logic [8:0] e_add;
        logic [8:0] e_sub;
        logic [7:0] e_res;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, 9-bit two's complement view.
    task automatic model(input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic ov,
                         output logic [8:0] ea, output logic [8:0] es,
                         output logic [7:0] er);
        int cin;
        int s;
        int d;
        cin = (op[1] && ov) ? 1 : 0;
        s = int'(a) + int'(b) + cin;
        d = int'(a) - int'(b) - cin;
        ea = s[8:0];
        es = d[8:0];
        er = op[0] ? ea[7:0] : es[7:0];
    endtask

    // One operation; inputs are scrambled while busy to prove they are ignored.
    task automatic do_op(input string tag, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic ov, input logic [8:0] ea,
                         input logic [8:0] es, input logic [7:0] er);
        int done_at;
        int pulses;
        int strobe_bad;
        logic busy1;
        logic [8:0] g_add;
        logic [8:0] g_sub;
        logic [7:0] g_res;
        logic [3:0] g_opc;
        logic [3:0] e_opc;
        e_opc = {3'b100, op[0]};
        done_at = 0;
        pulses = 0;
        strobe_bad = 0;
        busy1 = 1'b0;
        g_add = '0;
        g_sub = '0;
        g_res = '0;
        g_opc = '0;
        @(negedge CLK);
        ALU_EN = 1'b1;
        ALU_OPCode = op;
        ALU_A = a;
        ALU_B = b;
        OVREG_OV = ov;
        @(posedge CLK);
        #1;
        ALU_EN = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            if (ALU_Done) begin
                pulses++;
                if (done_at == 0) done_at = k;
            end
            if (OV_EN !== ALU_Done) strobe_bad++;
            if (k == 1) busy1 = ALU_Busy;
            if (k == 9) begin
                g_add = OVREG_Adder;
                g_sub = OVREG_Subtractor;
                g_res = ALU_Result;
                g_opc = OVREG_OV_OPCode;
            end
            if (k <= 8) begin
                ALU_EN = 1'($urandom);
                ALU_OPCode = {2'b10, 2'($urandom)};
                ALU_A = 8'($urandom);
                ALU_B = 8'($urandom);
                OVREG_OV = 1'($urandom);
            end else begin
                ALU_EN = 1'b0;
            end
        end
        chk({tag, " busy_start"}, 32'(busy1), 32'd1);
        chk({tag, " done_cycle"}, 32'(done_at), 32'd9);
        chk({tag, " done_pulses"}, 32'(pulses), 32'd1);
        chk({tag, " ov_en_eq_done"}, 32'(strobe_bad), 32'd0);
        chk({tag, " adder"}, 32'(g_add), 32'(ea));
        chk({tag, " subtractor"}, 32'(g_sub), 32'(es));
        chk({tag, " result"}, 32'(g_res), 32'(er));
        chk({tag, " ov_opcode"}, 32'(g_opc), 32'(e_opc));
        chk({tag, " busy_after"}, 32'(ALU_Busy), 32'd0);
        chk({tag, " adder_hold"}, 32'(OVREG_Adder), 32'(ea));
    endtask

    initial begin
        logic [8:0] ea;
        logic [8:0] es;
        logic [7:0] er;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       ov;
        int pulses;
        int busy_seen;
        int pk[$];
        logic [8:0] h_add;
        logic [8:0] h_sub;
        logic [7:0] h_res;
        logic [3:0] h_opc;
        logic [3:0] bad_ops[4];

        vecs[0] = '{4'b1001, 8'hFF, 8'h01, 1'b0, 9'h100, 9'h0FE, 8'h00};
        vecs[1] = '{4'b1000, 8'h10, 8'h20, 1'b0, 9'h030, 9'h1F0, 8'hF0};
        vecs[2] = '{4'b1011, 8'hFF, 8'hFF, 1'b1, 9'h1FF, 9'h1FF, 8'hFF};
        vecs[3] = '{4'b1010, 8'h00, 8'hFF, 1'b1, 9'h100, 9'h100, 8'h00};
        vecs[4] = '{4'b1011, 8'h7F, 8'h80, 1'b1, 9'h100, 9'h1FE, 8'h00};
        vecs[5] = '{4'b1010, 8'h50, 8'h30, 1'b0, 9'h080, 9'h020, 8'h20};
        vecs[6] = '{4'b1001, 8'h00, 8'h00, 1'b0, 9'h000, 9'h000, 8'h00};
        vecs[7] = '{4'b1001, 8'h7F, 8'h80, 1'b1, 9'h0FF, 9'h1FF, 8'hFF};
        vecs[8] = '{4'b1000, 8'h00, 8'h01, 1'b1, 9'h001, 9'h1FF, 8'hFF};

        bad_ops[0] = 4'b0101;
        bad_ops[1] = 4'b0001;
        bad_ops[2] = 4'b1101;
        bad_ops[3] = 4'b0000;

        // Reset with a valid start pending: reset must win.
        CPU_Reset = 1'b1;
        ALU_EN = 1'b1;
        ALU_OPCode = 4'b1001;
        ALU_A = 8'h55;
        ALU_B = 8'hAA;
        OVREG_OV = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst busy", 32'(ALU_Busy), 32'd0);
        chk("rst done", 32'(ALU_Done), 32'd0);
        chk("rst ov_en", 32'(OV_EN), 32'd0);
        chk("rst adder", 32'(OVREG_Adder), 32'd0);
        chk("rst sub", 32'(OVREG_Subtractor), 32'd0);
        chk("rst result", 32'(ALU_Result), 32'd0);
        chk("rst opc", 32'(OVREG_OV_OPCode), 32'd0);
        ALU_EN = 1'b0;
        CPU_Reset = 1'b0;

        foreach (vecs[i]) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].ov, vecs[i].e_add, vecs[i].e_sub, vecs[i].e_res);
        end

        // ALU_EN held high: back-to-back ops, done at +9 and +19 only.
        @(negedge CLK);
        ALU_EN = 1'b1;
        ALU_OPCode = 4'b1001;
        ALU_A = 8'h12;
        ALU_B = 8'h34;
        OVREG_OV = 1'b0;
        @(posedge CLK);
        pk.delete();
        busy_seen = 0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge CLK);
            if (ALU_Done) pk.push_back(k);
            if (k == 10) busy_seen = int'(ALU_Busy);
            if (k == 19) ALU_EN = 1'b0;
        end
        chk("hold_en pulses", 32'(pk.size()), 32'd2);
        if (pk.size() == 2) begin
            chk("hold_en first", 32'(pk[0]), 32'd9);
            chk("hold_en second", 32'(pk[1]), 32'd19);
        end
        chk("hold_en idle_gap", 32'(busy_seen), 32'd0);
        chk("hold_en busy_end", 32'(ALU_Busy), 32'd0);
        chk("hold_en adder", 32'(OVREG_Adder), 32'h046);

        // Reset during the 4th SHIFT cycle aborts silently.
        @(negedge CLK);
        ALU_EN = 1'b1;
        ALU_OPCode = 4'b1011;
        ALU_A = 8'hC3;
        ALU_B = 8'h5A;
        OVREG_OV = 1'b1;
        @(posedge CLK);
        #1;
        ALU_EN = 1'b0;
        for (int k = 1; k <= 4; k++) @(negedge CLK);
        CPU_Reset = 1'b1;
        @(negedge CLK);
        chk("abort busy", 32'(ALU_Busy), 32'd0);
        chk("abort done", 32'(ALU_Done), 32'd0);
        chk("abort ov_en", 32'(OV_EN), 32'd0);
        chk("abort adder", 32'(OVREG_Adder), 32'd0);
        chk("abort sub", 32'(OVREG_Subtractor), 32'd0);
        chk("abort result", 32'(ALU_Result), 32'd0);
        chk("abort opc", 32'(OVREG_OV_OPCode), 32'd0);
        CPU_Reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge CLK);
            if (ALU_Done || OV_EN) pulses++;
        end
        chk("abort no_pulse", 32'(pulses), 32'd0);

        // Give the outputs a nonzero value, then try invalid opcodes.
        do_op("pre_inv", 4'b1000, 8'h10, 8'h20, 1'b0, 9'h030, 9'h1F0, 8'hF0);
        h_add = OVREG_Adder;
        h_sub = OVREG_Subtractor;
        h_res = ALU_Result;
        h_opc = OVREG_OV_OPCode;
        pulses = 0;
        busy_seen = 0;
        foreach (bad_ops[i]) begin
            @(negedge CLK);
            ALU_EN = 1'b1;
            ALU_OPCode = bad_ops[i];
            ALU_A = 8'($urandom);
            ALU_B = 8'($urandom);
            for (int k = 0; k < 4; k++) begin
                @(negedge CLK);
                if (ALU_Busy) busy_seen++;
                if (ALU_Done || OV_EN) pulses++;
            end
        end
        ALU_EN = 1'b0;
        chk("inv busy", 32'(busy_seen), 32'd0);
        chk("inv pulses", 32'(pulses), 32'd0);
        chk("inv adder", 32'(OVREG_Adder), 32'(h_add));
        chk("inv sub", 32'(OVREG_Subtractor), 32'(h_sub));
        chk("inv result", 32'(ALU_Result), 32'(h_res));
        chk("inv opc", 32'(OVREG_OV_OPCode), 32'(h_opc));

        // Random valid operations against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            op = {2'b10, 2'($urandom)};
            a = 8'($urandom);
            b = 8'($urandom);
            ov = 1'($urandom);
            model(op, a, b, ov, ea, es, er);
            do_op($sformatf("rnd%0d", n), op, a, b, ov, ea, es, er);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_arith.md
SERIAL_ARITH -- requirements
Module: serial_arith

Interface
REQ-001 SHALL have no parameters; data width fixed at 8 bits, results 9 bits (bit 8 = carry/borrow).
REQ-002 SHALL use one clock and a synchronous, active-high reset, with ports exactly as follows:
- CLK  input  1  system clock, all state updates on rising edge.
- CPU_Reset  input  1  synchronous active-high reset.
REQ-003 SHALL have the remaining ports:
- ALU_EN  input  1  start request, sampled in IDLE only.
- ALU_OPCode  input  4  operation: 4'b1001 ADD, 4'b1000 SUB, 4'b1011 ADC, 4'b1010 SBB; all others invalid.
- ALU_A  input  8  operand A.
- ALU_B  input  8  operand B.
- OVREG_OV  input  1  overflow flag from the OV register, used as carry/borrow-in for ADC/SBB.
- OVREG_Adder  output  9  registered A+B+cin.
- OVREG_Subtractor  output  9  registered A-B-cin, bit 8 = borrow.
- ALU_Result  output  8  OVREG_Adder[7:0] if opcode[0]=1, else OVREG_Subtractor[7:0].
- OVREG_OV_OPCode  output  4  opcode presented to the OV register: {1'b1,1'b0,1'b0,opcode[0]}.
- OV_EN  output  1  one-cycle strobe to the OV register on completion.
- ALU_Busy  output  1  operation in progress.
- ALU_Done  output  1  one-cycle completion pulse.

Function
REQ-004 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-005 IDLE: on ALU_EN=1 with valid opcode, SHALL latch A, B, opcode, cin (OVREG_OV if opcode[1]=1, else 0) and go to SHIFT with bit counter 0; invalid opcode or ALU_EN=0 -> stay IDLE, no state change.
REQ-006 SHIFT: SHALL process one bit per cycle, LSB first, bit counter 0..7; sum bit = a^b^c, carry = ab|(a^b)c; diff bit = a^b^w, borrow = (~a&b)|(~(a^b)&w); c and w both start at latched cin.
REQ-007 SHIFT SHALL compute sum and difference in parallel for every opcode; after bit 7 -> DONE.
REQ-008 DONE: SHALL load OVREG_Adder={carry,sum}, OVREG_Subtractor={borrow,diff}, update ALU_Result and OVREG_OV_OPCode, assert ALU_Done=1 and OV_EN=1 for exactly this one cycle, then return to IDLE.
REQ-009 Latency: start accepted at edge N -> ALU_Done/OV_EN high during cycle N+9 (8 SHIFT + 1 DONE); new start accepted no earlier than edge N+10.
REQ-010 ALU_Busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-011 ALU_EN, ALU_A, ALU_B, ALU_OPCode, OVREG_OV SHALL be ignored outside IDLE; operands and cin sampled only at start.
REQ-012 Result outputs SHALL hold their last completed values until the next DONE.
REQ-013 Arithmetic SHALL be modulo 2^8 with bit 8 carry/borrow; 0xFF+0xFF+1 -> 0x1FF; 0x00-0xFF-1 -> 0x100.

Reset
REQ-014 CPU_Reset=1 at a rising edge SHALL force IDLE, counter 0, all outputs 0 (OVREG_Adder, OVREG_Subtractor, ALU_Result, OVREG_OV_OPCode, OV_EN, ALU_Busy, ALU_Done).
REQ-015 Reset SHALL take priority over any start or in-flight operation; an aborted operation SHALL produce no ALU_Done or OV_EN pulse.
REQ-016 Reset SHALL be synchronous only; no asynchronous path.

Verification
REQ-017 ADD A=0xFF B=0x01 -> cycle N+9: OVREG_Adder=0x100, OVREG_Subtractor=0x0FE, ALU_Result=0x00, OVREG_OV_OPCode=4'b1001, OV_EN=ALU_Done=1 one cycle.
REQ-018 SUB A=0x10 B=0x20 -> OVREG_Subtractor=0x1F0, ALU_Result=0xF0, OVREG_OV_OPCode=4'b1000.
REQ-019 ADC A=0x7F B=0x80 OVREG_OV=1 at start, OVREG_OV toggled during SHIFT -> OVREG_Adder=0x100 (cin from start only).
REQ-020 ALU_EN held high with ADD through a whole operation -> second op starts at edge N+10, ALU_Done pulses at N+9 and N+19, no extra pulses.
REQ-021 CPU_Reset asserted at 4th SHIFT cycle -> next cycle ALU_Busy=0, all outputs 0, no ALU_Done/OV_EN ever for that op.
REQ-022 ALU_EN=1 with ALU_OPCode=4'b0101 -> ALU_Busy stays 0, outputs unchanged, no pulses.
